// File: rtl/ram_fifo_pkg.sv
// Shared constants and helpers for the RAM-backed FIFO controller.
//   RAM_READ_LATENCY : cycles from raddr presentation to valid ram_dout
//   SKID_DEPTH       : entries in the first-word-fall-through output skid
//   level_width()    : bits needed to hold 0 .. 2**addr_width + SKID_DEPTH
package ram_fifo_pkg;

    localparam int RAM_READ_LATENCY = 1;
    localparam int SKID_DEPTH       = 2;

    function automatic int level_width(input int addr_width);
        return $clog2((2 ** addr_width) + SKID_DEPTH + 1);
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry registered FIFO sitting after the RAM read port. Entry 0 is
// always the oldest word and drives rd_data directly from a flop.
// Ports:
//   clk, reset_n (async, active-low), flush (sync clear)
//   wr_en / wr_data : capture a word returned by the RAM
//   rd_en           : pop the oldest entry (ignored when empty)
//   rd_data         : oldest entry
//   occ             : number of valid entries (0..2)
// The controller never writes when full unless it also pops that cycle.
module fifo_skid_buf #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] r_mem0;
    logic [DATA_WIDTH-1:0] r_mem1;
    logic [1:0]            r_occ;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem0 <= '0;
            r_mem1 <= '0;
            r_occ  <= 2'd0;
        end else if (flush) begin
            r_occ <= 2'd0;
        end else begin
            case (r_occ)
                2'd0: begin
                    if (wr_en) begin
                        r_mem0 <= wr_data;
                        r_occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({wr_en, rd_en})
                        2'b11: r_mem0 <= wr_data;
                        2'b10: begin
                            r_mem1 <= wr_data;
                            r_occ  <= 2'd2;
                        end
                        2'b01: r_occ <= 2'd0;
                        default: ;
                    endcase
                end
                2'd2: begin
                    // Pop shifts the younger entry forward; a same-cycle
                    // capture refills the back slot.
                    if (rd_en) begin
                        r_mem0 <= r_mem1;
                        if (wr_en) r_mem1 <= wr_data;
                        else       r_occ  <= 2'd1;
                    end
                end
                default: r_occ <= 2'd0;
            endcase
        end
    end

    assign rd_data = r_mem0;
    assign occ     = r_occ;

endmodule

// File: rtl/ram_fifo_ctl.sv
// Valid/ready FIFO controller for a 1-read-latency dual-port RAM. Holds
// the write/read pointers, the count of words parked in RAM, the read
// in-flight flag and the issue logic; a 2-entry skid makes the pop side
// first-word-fall-through at one word per clock.
// Ports:
//   clk, reset_n (async, active-low), flush (sync clear, beats push/pop)
//   in_valid/in_ready/in_data     : push side
//   out_valid/out_ready/out_data  : pop side, out_data registered
//   ram_waddr/ram_din/ram_we      : RAM write port
//   ram_raddr/ram_dout            : RAM read port, dout valid next cycle
//   level/almost_full             : occupancy (only with RAM_FIFO_LEVEL_EN)
// Build option: define RAM_FIFO_LEVEL_EN to get a registered level and
// almost_full; otherwise both outputs are tied low.
module ram_fifo_ctl
    import ram_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH         = 5,
    parameter int DATA_WIDTH         = 32,
    parameter int ALMOST_FULL_THRESH = 28
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  almost_full
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CW-1:0]         r_ram_cnt;
    logic                  r_rd_inflight;

    logic [1:0]            w_skid_occ;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    logic [2:0]            w_pending;
    logic [CW-1:0]         w_cnt_nxt;

    // in_ready depends on registered state only.
    assign in_ready  = (r_ram_cnt != FULL_CNT);
    assign out_valid = (w_skid_occ != 2'd0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // Skid slots already spoken for after this cycle's pop; a read may only
    // be issued if its data will have somewhere to land next cycle.
    assign w_pending = 3'(w_skid_occ) + 3'(r_rd_inflight) - 3'(w_pop);
    assign w_issue   = !flush && (r_ram_cnt != '0) && (w_pending < 3'(SKID_DEPTH));
    assign w_cnt_nxt = r_ram_cnt + CW'(w_push) - CW'(w_issue);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_ram_cnt     <= '0;
            r_rd_inflight <= 1'b0;
        end else if (flush) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_ram_cnt     <= '0;
            r_rd_inflight <= 1'b0;
        end else begin
            if (w_push)  r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            if (w_issue) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            r_ram_cnt     <= w_cnt_nxt;
            r_rd_inflight <= w_issue;
        end
    end

    assign ram_waddr = r_wr_ptr;
    assign ram_raddr = r_rd_ptr;
    assign ram_din   = in_data;
    assign ram_we    = w_push;

    // Data for a read issued last cycle is on ram_dout now; a flush this
    // cycle makes the skid drop it.
    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .wr_en   (r_rd_inflight),
        .wr_data (ram_dout),
        .rd_en   (w_pop),
        .rd_data (out_data),
        .occ     (w_skid_occ)
    );

`ifdef RAM_FIFO_LEVEL_EN
    localparam int LVL_W = level_width(ADDR_WIDTH);

    logic [LVL_W-1:0] r_level;
    logic [2:0]       w_occ_nxt;

    assign w_occ_nxt = 3'(w_skid_occ) + 3'(r_rd_inflight) - 3'(w_pop);

    // Built from next-state values so level matches the state after the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   r_level <= '0;
        else if (flush) r_level <= '0;
        else            r_level <= LVL_W'(w_cnt_nxt) + LVL_W'(w_issue) + LVL_W'(w_occ_nxt);
    end

    assign level       = (ADDR_WIDTH + 2)'(r_level);
    assign almost_full = (int'(r_level) >= ALMOST_FULL_THRESH);
`else
    assign level       = '0;
    assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_ram_fifo_ctl.sv
module tb_ram_fifo_ctl;

    localparam int AW  = 3;
    localparam int DW  = 32;
    localparam int CAP = (2 ** AW) + 2;
    localparam int AF  = 8;

    logic          clk;
    logic          reset_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] ram_waddr;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout;
    logic [AW+1:0] level;
    logic          almost_full;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] q[$];
    logic last_push;
    logic last_pop;

    ram_fifo_ctl #(
        .ADDR_WIDTH         (AW),
        .DATA_WIDTH         (DW),
        .ALMOST_FULL_THRESH (AF)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .ram_waddr   (ram_waddr),
        .ram_raddr   (ram_raddr),
        .ram_din     (ram_din),
        .ram_we      (ram_we),
        .ram_dout    (ram_dout),
        .level       (level),
        .almost_full (almost_full)
    );

    // 1-cycle-latency dual-port RAM, read-before-write on address collision.
    logic [DW-1:0] mem [2 ** AW];
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_din;
        ram_dout <= mem[ram_raddr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_level();
`ifdef RAM_FIFO_LEVEL_EN
        return 64'(q.size());
`else
        return 64'd0;
`endif
    endfunction

    function automatic logic [63:0] exp_af();
`ifdef RAM_FIFO_LEVEL_EN
        return (q.size() >= AF) ? 64'd1 : 64'd0;
`else
        return 64'd0;
`endif
    endfunction

    // One clock: sample handshakes at negedge, advance the queue model at the
    // edge, then check occupancy just after it.
    task automatic step();
        @(negedge clk);
        last_push = in_valid && in_ready;
        last_pop  = out_valid && out_ready;
        if (out_valid && !flush) begin
            chk("head_present", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) chk("head_data", 64'(out_data), 64'(q[0]));
        end
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (last_pop && q.size() > 0) void'(q.pop_front());
            if (last_push) q.push_back(in_data);
        end
        #1;
        chk("level", 64'(level), exp_level());
        chk("almost_full", 64'(almost_full), exp_af());
        if (q.size() == CAP) chk("full_in_ready", 64'(in_ready), 64'd0);
    endtask

    task automatic drain(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && q.size() > 0; i++) step();
        chk(tag, 64'(q.size()), 64'd0);
    endtask

    initial begin
        int accepted;
        int pushed;
        int popped;
        int cyc;

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #22;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_almost_full", 64'(almost_full), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);

        // 1: single word latency
        in_valid = 1'b1; in_data = 32'hA5A5_0001; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_ov_e0", 64'(out_valid), 64'd0);
        step();
        chk("t1_ov_e1", 64'(out_valid), 64'd0);
        step();
        chk("t1_ov_e2", 64'(out_valid), 64'd1);
        chk("t1_data", 64'(out_data), 64'hA5A5_0001);
        step();
        chk("t1_popped", 64'(last_pop), 64'd1);
        chk("t1_ov_after", 64'(out_valid), 64'd0);

        // 2: fill to capacity with no pops, then drain in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        accepted  = 0;
        for (int i = 0; i < 14; i++) begin
            in_data = 32'h2000_0000 + 32'(i);
            step();
            if (last_push) accepted++;
        end
        chk("t2_accepted", 64'(accepted), 64'(CAP));
        chk("t2_in_ready_low", 64'(in_ready), 64'd0);
        drain("t2_drained");

        // 3: continuous push+pop, no bubbles once the first word is out
        pushed = 0; popped = 0;
        out_ready = 1'b1;
        for (cyc = 0; cyc < 200 && popped < 100; cyc++) begin
            in_valid = (pushed < 100);
            in_data  = 32'(pushed);
            step();
            if (last_push) pushed++;
            if (last_pop) popped++;
            if (popped > 0 && popped < 100) chk("t3_no_bubble", 64'(out_valid), 64'd1);
        end
        chk("t3_popped", 64'(popped), 64'd100);

        // 4: push+pop while full: pop taken, push refused, in_ready back next cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 20 && q.size() < CAP; i++) begin
            in_data = 32'h4000_0000 + 32'(i);
            step();
        end
        chk("t4_full", 64'(in_ready), 64'd0);
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        step();
        chk("t4_push_refused", 64'(last_push), 64'd0);
        chk("t4_pop_taken", 64'(last_pop), 64'd1);
        chk("t4_in_ready_next", 64'(in_ready), 64'd1);
        drain("t4_drained");

        // 5: random traffic, many pointer wraps
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            step();
        end
        drain("t5_drained");

        // 6: flush with a read in flight, then async reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'h6000_0000 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        chk("t6_flush_ov", 64'(out_valid), 64'd0);
        chk("t6_flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("t6_flush_quiet", 64'(out_valid), 64'd0);

        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data = 32'h7000_0000 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        q.delete();
        #1;
        chk("t6_rst_ov", 64'(out_valid), 64'd0);
        chk("t6_rst_level", 64'(level), 64'd0);
        chk("t6_rst_in_ready", 64'(in_ready), 64'd1);
        #10;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_data   = 32'h0000_1234;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        last_pop = 1'b0;
        for (int i = 0; i < 10 && !last_pop; i++) step();
        chk("t6_word_out", 64'(last_pop), 64'd1);
        chk("t6_empty", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
